// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       zero;
   logic       neg;
   logic       mem_ready;
   logic       pc_we;
   logic       ir_we;
   logic       adr_src;
   logic       mem_we;
   logic       reg_we;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [2:0] imm_src;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  opcode, func3, zero, neg, mem_ready,
      output pc_we, ir_we, adr_src, mem_we, reg_we, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal
   );

   modport slave (
      output opcode, func3, zero, neg, mem_ready,
      input  pc_we, ir_we, adr_src, mem_we, reg_we, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// FSM control unit for a shared-memory, single-ALU multi-cycle RV32I subset.
// State and the sticky illegal flag are registered; controls decode from state.
module multicycle_controller #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input logic                     clk,
   input logic                     rst_n,
   multicycle_controller_if.master bus
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I,
      ALU_WB, BRANCH, JAL, JALR1, JALR2, LUI, ERROR
   } state_t;

   state_t state_q, state_d;
   logic   illegal_q;
   state_t bad_state;

   logic       pc_we, ir_we, adr_src, mem_we, reg_we, instr_done;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [2:0] imm_src;

   assign bad_state = HALT_ON_ILLEGAL ? ERROR : FETCH;

   always_comb begin
      state_d    = state_q;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      adr_src    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 3'b000;
      unique case (state_q)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (bus.mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            if (bus.opcode == OP_BR)       imm_src = 3'b010;
            else if (bus.opcode == OP_JAL) imm_src = 3'b011;
            case (bus.opcode)
               OP_R:         state_d = EXEC_R;
               OP_I:         state_d = EXEC_I;
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_BR: begin
                  case (bus.func3)
                     3'b000, 3'b001, 3'b100, 3'b101: state_d = BRANCH;
                     default:                        state_d = bad_state;
                  endcase
               end
               OP_JAL:       state_d = JAL;
               OP_JALR:      state_d = JALR1;
               OP_LUI:       state_d = LUI;
               default:      state_d = bad_state;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            // opcode bit 5 separates sw (S-immediate) from lw
            imm_src   = bus.opcode[5] ? 3'b001 : 3'b000;
            state_d   = bus.opcode[5] ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            result_src = 2'b01;
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         MEM_WR: begin
            adr_src = 1'b1;
            mem_we  = 1'b1;
            if (bus.mem_ready) begin
               instr_done = 1'b1;
               state_d    = FETCH;
            end
         end
         EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = ALU_WB;
         end
         EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b11;
            state_d   = ALU_WB;
         end
         ALU_WB: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            instr_done = 1'b1;
            case (bus.func3)
               3'b000:  pc_we = bus.zero;
               3'b001:  pc_we = ~bus.zero;
               3'b100:  pc_we = bus.neg;
               3'b101:  pc_we = ~bus.neg;
               default: pc_we = 1'b0;
            endcase
            state_d = FETCH;
         end
         JAL, JALR2: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_we     = 1'b1;
            state_d   = ALU_WB;
         end
         JALR1: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = JALR2;
         end
         LUI: begin
            imm_src    = 3'b100;
            result_src = 2'b11;
            reg_we     = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
         end
         ERROR: state_d = ERROR;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= (state_d == ERROR);
      end
   end

   // Write strobes are gated directly by rst_n so an in-flight access dies the instant reset falls.
   assign bus.pc_we      = pc_we & rst_n;
   assign bus.ir_we      = ir_we & rst_n;
   assign bus.mem_we     = mem_we & rst_n;
   assign bus.reg_we     = reg_we & rst_n;
   assign bus.instr_done = instr_done & rst_n;
   assign bus.adr_src    = adr_src;
   assign bus.result_src = result_src;
   assign bus.alu_src_a  = alu_src_a;
   assign bus.alu_src_b  = alu_src_b;
   assign bus.alu_op     = alu_op;
   assign bus.imm_src    = imm_src;
   assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of instructions with expected per-instruction
// strobe counts/latency via a scoreboard queue, plus hand sequences for reset/illegal cases.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst_n, rst1_n;
   always #5 clk = ~clk;

   multicycle_controller_if m0 ();
   multicycle_controller_if m1 ();

   multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut0 (.clk(clk), .rst_n(rst_n),  .bus(m0));
   multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(m1));

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        z;
      logic        n;
      logic [39:0] stall;
      int unsigned lat;
      int unsigned pcw;
      int unsigned rw;
      int unsigned mw;
      logic [1:0]  rs;
      logic [1:0]  pa;
      logic [1:0]  pb;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic z, input logic n, input logic [39:0] stall,
                               input int unsigned lat, input int unsigned pcw,
                               input int unsigned rw, input int unsigned mw,
                               input logic [1:0] rs, input logic [1:0] pa, input logic [1:0] pb);
      vec_t v;
      v.name = name; v.op = op; v.f3 = f3; v.z = z; v.n = n; v.stall = stall;
      v.lat = lat; v.pcw = pcw; v.rw = rw; v.mw = mw; v.rs = rs; v.pa = pa; v.pb = pb;
      return v;
   endfunction

   task automatic step(input logic mr);
      @(negedge clk);
      m0.mem_ready = mr;
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned cyc, pcw, irw, rw, mw, dn;
      logic [1:0] rs, pa, pb;
      vec_t e;
      cyc = 0; pcw = 0; irw = 0; rw = 0; mw = 0; dn = 0;
      rs = 2'b00; pa = 2'b00; pb = 2'b00;
      sb.push_back(v);
      while (dn == 0 && cyc < 40) begin
         @(negedge clk);
         m0.opcode = v.op; m0.func3 = v.f3; m0.zero = v.z; m0.neg = v.n;
         m0.mem_ready = ~v.stall[cyc];
         #1;
         cyc++;
         if (m0.pc_we) begin
            pcw++;
            if (cyc > 1) begin pa = m0.alu_src_a; pb = m0.alu_src_b; end
         end
         if (m0.ir_we)  irw++;
         if (m0.mem_we) mw++;
         if (m0.reg_we) begin rw++; rs = m0.result_src; end
         if (m0.instr_done) dn++;
      end
      e = sb.pop_front();
      chk({e.name, " done"},    dn,  1);
      chk({e.name, " latency"}, cyc, e.lat);
      chk({e.name, " pc_we"},   pcw, e.pcw);
      chk({e.name, " ir_we"},   irw, 1);
      chk({e.name, " reg_we"},  rw,  e.rw);
      chk({e.name, " mem_we"},  mw,  e.mw);
      if (e.rw > 0) chk({e.name, " result_src"}, {30'd0, rs}, {30'd0, e.rs});
      if (e.pcw > 1) begin
         chk({e.name, " alu_src_a"}, {30'd0, pa}, {30'd0, e.pa});
         chk({e.name, " alu_src_b"}, {30'd0, pb}, {30'd0, e.pb});
      end
   endtask

   task automatic illegal_halt(input string name, input logic [6:0] op, input logic [2:0] f3);
      m0.opcode = op; m0.func3 = f3;
      step(1'b1);
      step(1'b1);
      chk({name, " decode illegal"}, {31'd0, m0.illegal}, 0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         chk({name, " err illegal"}, {31'd0, m0.illegal}, 1);
         chk({name, " err enables"},
             {27'd0, m0.pc_we, m0.ir_we, m0.mem_we, m0.reg_we, m0.instr_done}, 0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk({name, " rst illegal"}, {31'd0, m0.illegal}, 0);
      chk({name, " rst alu_src_b"}, {30'd0, m0.alu_src_b}, 2);
      chk({name, " rst ir_we"}, {31'd0, m0.ir_we}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m0.mem_ready = 1'b0;
      m0.opcode = 7'b0110011;
      #1;
      chk({name, " post-rst pc_we"}, {31'd0, m0.pc_we}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst1_n = 1'b0;
      m0.opcode = 7'b0110011; m0.func3 = 3'b000; m0.zero = 1'b0; m0.neg = 1'b0; m0.mem_ready = 1'b1;
      m1.opcode = 7'b0110011; m1.func3 = 3'b000; m1.zero = 1'b0; m1.neg = 1'b0; m1.mem_ready = 1'b0;

      tbl.push_back(mk("add",     7'b0110011, 3'b000, 0, 0, 40'h0,  4, 1, 1, 0, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("addi",    7'b0010011, 3'b000, 0, 0, 40'h0,  4, 1, 1, 0, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("lw",      7'b0000011, 3'b010, 0, 0, 40'h0,  5, 1, 1, 0, 2'b01, 2'b00, 2'b00));
      tbl.push_back(mk("sw",      7'b0100011, 3'b010, 0, 0, 40'h0,  4, 1, 0, 1, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("beq_t",   7'b1100011, 3'b000, 1, 0, 40'h0,  3, 2, 0, 0, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mk("beq_n",   7'b1100011, 3'b000, 0, 0, 40'h0,  3, 1, 0, 0, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("bne_z1",  7'b1100011, 3'b001, 1, 0, 40'h0,  3, 1, 0, 0, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("bne_z0",  7'b1100011, 3'b001, 0, 0, 40'h0,  3, 2, 0, 0, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mk("blt_n1",  7'b1100011, 3'b100, 0, 1, 40'h0,  3, 2, 0, 0, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mk("bge_n1",  7'b1100011, 3'b101, 0, 1, 40'h0,  3, 1, 0, 0, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mk("bge_n0",  7'b1100011, 3'b101, 0, 0, 40'h0,  3, 2, 0, 0, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mk("jal",     7'b1101111, 3'b000, 0, 0, 40'h0,  4, 2, 1, 0, 2'b00, 2'b01, 2'b10));
      tbl.push_back(mk("jalr",    7'b1100111, 3'b000, 0, 0, 40'h0,  5, 2, 1, 0, 2'b00, 2'b01, 2'b10));
      tbl.push_back(mk("lui",     7'b0110111, 3'b000, 0, 0, 40'h0,  3, 1, 1, 0, 2'b11, 2'b00, 2'b00));
      tbl.push_back(mk("lw_stl",  7'b0000011, 3'b010, 0, 0, 40'hC7, 10, 1, 1, 0, 2'b01, 2'b00, 2'b00));
      tbl.push_back(mk("sw_stl",  7'b0100011, 3'b010, 0, 0, 40'h18, 6, 1, 0, 3, 2'b00, 2'b00, 2'b00));

      #2;
      chk("reset pc_we",     {31'd0, m0.pc_we}, 0);
      chk("reset ir_we",     {31'd0, m0.ir_we}, 0);
      chk("reset illegal",   {31'd0, m0.illegal}, 0);
      chk("reset adr_src",   {31'd0, m0.adr_src}, 0);
      chk("reset alu_src_b", {30'd0, m0.alu_src_b}, 2);
      chk("reset result_src",{30'd0, m0.result_src}, 2);

      @(negedge clk);
      rst_n = 1'b1; rst1_n = 1'b1;
      m0.mem_ready = 1'b0;
      #1;
      chk("fetch wait pc_we", {31'd0, m0.pc_we}, 0);

      foreach (tbl[i]) run_vec(tbl[i]);

      illegal_halt("op7f", 7'b1111111, 3'b000);
      illegal_halt("br010", 7'b1100011, 3'b010);

      // Non-halting variant: illegal opcode falls back to FETCH with no writes
      @(negedge clk);
      m1.opcode = 7'b1111111; m1.mem_ready = 1'b1;
      #1;
      chk("nohalt fetch ir_we", {31'd0, m1.ir_we}, 1);
      @(negedge clk); #1;
      chk("nohalt decode writes",
          {27'd0, m1.pc_we, m1.ir_we, m1.mem_we, m1.reg_we, m1.instr_done}, 0);
      @(negedge clk); #1;
      chk("nohalt refetch ir_we", {31'd0, m1.ir_we}, 1);
      chk("nohalt illegal", {31'd0, m1.illegal}, 0);
      m1.mem_ready = 1'b0;

      // Reset dropped while a store is waiting in MEM_WR
      m0.opcode = 7'b0100011; m0.func3 = 3'b010;
      step(1'b1); step(1'b1); step(1'b1); step(1'b0);
      chk("memwr mem_we", {31'd0, m0.mem_we}, 1);
      chk("memwr adr_src", {31'd0, m0.adr_src}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort mem_we", {31'd0, m0.mem_we}, 0);
      chk("abort adr_src", {31'd0, m0.adr_src}, 0);
      chk("abort instr_done", {31'd0, m0.instr_done}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m0.mem_ready = 1'b0;
      #1;
      chk("rel pc_we", {31'd0, m0.pc_we}, 0);
      chk("rel ir_we", {31'd0, m0.ir_we}, 0);
      step(1'b0);
      chk("rel hold pc_we", {31'd0, m0.pc_we}, 0);
      step(1'b1);
      chk("rel ready pc_we", {31'd0, m0.pc_we}, 1);
      chk("rel ready ir_we", {31'd0, m0.ir_we}, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
